decoder3x8_hold: RTL and testbench
==================================

# decoder3x8_hold

Registered 3-to-8 one-hot decoder with a valid/ready input handshake and a programmable output hold time. Accepts a 3-bit code, drives the matching one-hot line for HOLD_CYCLES clocks, then returns to all-zero. It sits downstream of the 8-to-3 encoder and reconstructs the one-hot select lines from the encoded value.

## Interface
- HOLD_CYCLES, 4: number of cycles y stays asserted per accepted code; legal range 1..255.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  active-high disable/abort, same polarity as the encoder's en; while 1, no input is accepted and outputs are forced to zero.
- in_valid  in  1  code is presented.
- in_ready  out  1  block can accept a code this cycle.
- code  in  3  binary code to decode.
- code_par  in  1  even-parity bit over code; present only with DECODER_PARITY_EN.
- y  out  8  registered one-hot output; 8'h00 when idle.
- y_valid  out  1  y holds a decoded value.
- err  out  1  one-cycle pulse on parity mismatch; tied 0 without DECODER_PARITY_EN.

## Operation
- Reset (rst_n=0, asynchronous): state IDLE, y=8'h00, y_valid=0, err=0, hold counter=0.
- State IDLE:
  - in_ready = !en.
  - Handshake fires when in_valid && in_ready are both high at a rising edge.
  - On handshake: y <= 8'b1 << code, y_valid <= 1, counter <= HOLD_CYCLES-1, state <= HOLD.
- State HOLD:
  - in_ready=0. in_valid is ignored, and the code is not latched.
  - When counter != 0: the counter decrements.
  - When counter == 0: y <= 0, y_valid <= 0, state <= IDLE.
- en=1 in any state: at the next edge, state <= IDLE, y <= 0, y_valid <= 0, counter <= 0. en has priority over the handshake and over the hold countdown.
- Exactly one bit of y is set whenever y_valid=1. y is 8'h00 whenever y_valid=0. The block never drives Z or X.
- Mid-operation reset clears everything immediately, and no output pulse completes.

## Timing
- Latency: handshake at edge N, so y and y_valid are high from after edge N through edge N+HOLD_CYCLES.
- y and y_valid fall after edge N+HOLD_CYCLES. in_ready rises in the same cycle (when en=0).
- Earliest next handshake is edge N+HOLD_CYCLES+1. Throughput is one code per HOLD_CYCLES+1 cycles.
- in_ready is a function of registered state and en only. It has no combinational path from in_valid.
- HOLD_CYCLES=1: y is high for exactly one cycle, with one idle cycle between codes.

## Configuration
- DECODER_PARITY_EN defined:
  - code_par port exists.
  - On handshake, if code_par != ^code, the code is consumed, y and y_valid stay 0, err pulses 1 for the cycle after the edge, and state stays IDLE.
  - A valid parity decodes normally.
- DECODER_PARITY_EN undefined: no code_par port, err is constant 0, and every handshake decodes.

## Structure
- Shared package decoder_pkg contains:
  - state enum typedef (IDLE, HOLD);
  - constant for the one-hot width (8);
  - constant for the code width (3);
  - the HOLD_CYCLES legal-range bounds.
- One natural sub-module, onehot_dec3: a purely combinational 3-bit to 8-bit one-hot table. The top registers its output.
- The top contains the FSM, the hold counter (width $clog2(HOLD_CYCLES+1)), and the parity check.

## Test plan
- Reset with rst_n asserted mid-hold (code=3 active) -> y=8'h00 and y_valid=0 immediately (asynchronous), state IDLE, in_ready=1 after release with en=0.
- HOLD_CYCLES=4, code=3'd3 handshake at edge N -> y=8'h08 and y_valid=1 for exactly 4 cycles, then 8'h00; in_ready=0 throughout the hold.
- in_valid held high with code=7, then 0 -> y=8'h80 for 4 cycles, 1 idle cycle, then y=8'h01; no code is lost and none is duplicated.
- en=1 during the second hold cycle of code=5 -> y=8'h00 after the next edge, in_ready=0 while en=1, in_ready=1 the cycle en returns to 0.
- DECODER_PARITY_EN, code=3'b011 with code_par=1 -> err=1 for one cycle, y stays 8'h00, in_ready stays 1; the same code with code_par=0 -> y=8'h08.
- HOLD_CYCLES=1 sweep of all codes 0..7 -> y equals 1<<code for one cycle each, at a period of 2 cycles.

Source files
------------

// File: rtl/decoder_pkg.sv
// decoder_pkg: definitions shared by the decoder3x8_hold block.
//   state_t   - FSM states of the decoder (IDLE, HOLD)
//   ONEHOT_W  - width of the one-hot output (8)
//   CODE_W    - width of the binary code (3)
//   HOLD_MIN / HOLD_MAX - legal range of the HOLD_CYCLES parameter
package decoder_pkg;

  localparam int ONEHOT_W = 8;
  localparam int CODE_W   = 3;
  localparam int HOLD_MIN = 1;
  localparam int HOLD_MAX = 255;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/onehot_dec3.sv
// onehot_dec3: purely combinational 3-bit binary to 8-bit one-hot table.
//   code_i   in  3  binary code
//   onehot_o out 8  one-hot line matching code_i
module onehot_dec3
  import decoder_pkg::*;
(
  input  logic [CODE_W-1:0]   code_i,
  output logic [ONEHOT_W-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    case (code_i)
      3'd0: onehot_o = 8'h01;
      3'd1: onehot_o = 8'h02;
      3'd2: onehot_o = 8'h04;
      3'd3: onehot_o = 8'h08;
      3'd4: onehot_o = 8'h10;
      3'd5: onehot_o = 8'h20;
      3'd6: onehot_o = 8'h40;
      3'd7: onehot_o = 8'h80;
      default: onehot_o = '0;
    endcase
  end

endmodule

// File: rtl/decoder3x8_hold.sv
// decoder3x8_hold: registered 3-to-8 one-hot decoder with a valid/ready
// input handshake. An accepted code drives its one-hot line for HOLD_CYCLES
// clocks, after which y returns to zero and a new code can be taken.
//
// Parameter:
//   HOLD_CYCLES  cycles y stays asserted per accepted code (1..255)
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   en        in   active-high abort/disable; forces outputs to zero
//   in_valid  in   a code is presented
//   in_ready  out  block can accept a code this cycle
//   code      in   3-bit binary code
//   code_par  in   even-parity bit over code (DECODER_PARITY_EN only)
//   y         out  registered one-hot output, 8'h00 when idle
//   y_valid   out  y holds a decoded value
//   err       out  one-cycle parity-mismatch pulse (0 without parity)
//
// Build option: define DECODER_PARITY_EN to add the code_par input and the
// parity check that drives err.
module decoder3x8_hold
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CODE_W-1:0]   code,
`ifdef DECODER_PARITY_EN
  input  logic                code_par,
`endif
  output logic [ONEHOT_W-1:0] y,
  output logic                y_valid,
  output logic                err
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  if (HOLD_CYCLES < HOLD_MIN || HOLD_CYCLES > HOLD_MAX) begin : g_bad_hold
    $error("decoder3x8_hold: HOLD_CYCLES out of range");
  end

  state_t              state_q, state_d;
  logic [ONEHOT_W-1:0] y_q, y_d;
  logic                y_valid_q, y_valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ONEHOT_W-1:0] dec_y;
  logic                accept;
  logic                par_fail;

  onehot_dec3 u_dec (
    .code_i   (code),
    .onehot_o (dec_y)
  );

  // in_ready depends only on registered state and en, never on in_valid.
  assign in_ready = (state_q == IDLE) && !en;
  assign accept   = in_valid && in_ready;

`ifdef DECODER_PARITY_EN
  assign par_fail = (code_par != ^code);
`else
  assign par_fail = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    cnt_d     = cnt_q;
    if (en) begin
      // Abort wins over both the handshake and the countdown.
      state_d   = IDLE;
      y_d       = '0;
      y_valid_d = 1'b0;
      cnt_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // A code with bad parity is consumed but not decoded.
          if (accept && !par_fail) begin
            y_d       = dec_y;
            y_valid_d = 1'b1;
            cnt_d     = CNT_LOAD;
            state_d   = HOLD;
          end
        end
        HOLD: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            y_d       = '0;
            y_valid_d = 1'b0;
            state_d   = IDLE;
          end
        end
        default: begin
          state_d   = IDLE;
          y_d       = '0;
          y_valid_d = 1'b0;
          cnt_d     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef DECODER_PARITY_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && par_fail;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign y       = y_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_decoder3x8_hold.sv
module tb_decoder3x8_hold;

  typedef struct {
    logic [7:0] y;
    int         len;
    int         gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_s       [2];
  logic       in_valid_s [2];
  logic       in_ready_s [2];
  logic [2:0] code_s     [2];
  logic [7:0] y_s        [2];
  logic       yv_s       [2];
  logic       err_s      [2];
`ifdef DECODER_PARITY_EN
  logic       par_s      [2];
`endif

  int   checks = 0;
  int   fails  = 0;
  bit   mon_on = 1'b0;
  exp_t q [2][$];

  always #5 clk = ~clk;

  // dut 0: HOLD_CYCLES=4, dut 1: HOLD_CYCLES=1
  decoder3x8_hold #(.HOLD_CYCLES(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en_s[0]),
    .in_valid (in_valid_s[0]),
    .in_ready (in_ready_s[0]),
    .code     (code_s[0]),
`ifdef DECODER_PARITY_EN
    .code_par (par_s[0]),
`endif
    .y        (y_s[0]),
    .y_valid  (yv_s[0]),
    .err      (err_s[0])
  );

  decoder3x8_hold #(.HOLD_CYCLES(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en_s[1]),
    .in_valid (in_valid_s[1]),
    .in_ready (in_ready_s[1]),
    .code     (code_s[1]),
`ifdef DECODER_PARITY_EN
    .code_par (par_s[1]),
`endif
    .y        (y_s[1]),
    .y_valid  (yv_s[1]),
    .err      (err_s[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Present one code; the handshake happens at the next rising edge.
  task automatic send(input int idx, input logic [2:0] c);
    in_valid_s[idx] = 1'b1;
    code_s[idx]     = c;
`ifdef DECODER_PARITY_EN
    par_s[idx]      = ^c;
`endif
    @(posedge clk); #1;
    in_valid_s[idx] = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_ready(input int idx);
    int n = 0;
    while (in_ready_s[idx] !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      checks++;
      fails++;
      $display("FAIL wait_ready_dut%0d actual=timeout required=in_ready", idx);
    end
  endtask

  // Monitor: pops an expected pulse on each rising y_valid and checks value,
  // one-hot shape, pulse length and spacing between pulse starts.
  initial begin
    exp_t cur [2];
    bit   prev [2];
    bit   active [2];
    int   run [2];
    int   last_rise [2];
    int   cyc = 0;
    for (int i = 0; i < 2; i++) begin
      prev[i] = 1'b0; active[i] = 1'b0; run[i] = 0; last_rise[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (mon_on) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
          if (yv_s[i] === 1'b1) begin
            if (!prev[i]) begin
              run[i] = 0;
              if (q[i].size() == 0) begin
                checks++;
                fails++;
                active[i] = 1'b0;
                $display("FAIL dut%0d_unexpected_pulse actual y=%0h required no pulse", i, y_s[i]);
              end else begin
                cur[i]    = q[i].pop_front();
                active[i] = 1'b1;
                if (cur[i].gap != 0)
                  chk($sformatf("dut%0d_period", i), cyc - last_rise[i], cur[i].gap);
                last_rise[i] = cyc;
              end
            end
            run[i]++;
            chk($sformatf("dut%0d_onehot", i), $countones(y_s[i]), 1);
            if (active[i]) chk($sformatf("dut%0d_y", i), y_s[i], cur[i].y);
          end else begin
            if (prev[i] && active[i]) begin
              chk($sformatf("dut%0d_pulse_len", i), run[i], cur[i].len);
              active[i] = 1'b0;
            end
            chk($sformatf("dut%0d_y_idle", i), y_s[i], 8'h00);
          end
          prev[i] = (yv_s[i] === 1'b1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en_s[i] = 1'b0; in_valid_s[i] = 1'b0; code_s[i] = 3'd0;
`ifdef DECODER_PARITY_EN
      par_s[i] = 1'b0;
`endif
    end
    cycles(2);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_y_dut%0d", i), y_s[i], 8'h00);
      chk($sformatf("rst_yv_dut%0d", i), yv_s[i], 1'b0);
      chk($sformatf("rst_err_dut%0d", i), err_s[i], 1'b0);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    chk("rst_ready_dut4", in_ready_s[0], 1'b1);
    chk("rst_ready_dut1", in_ready_s[1], 1'b1);
    mon_on = 1'b1;
    cycles(1);

    // code 3 on HOLD=4: 8'h08 for four cycles, not ready during the hold
    q[0].push_back('{y: 8'h08, len: 4, gap: 0});
    send(0, 3'd3);
    for (int k = 0; k < 4; k++) begin
      chk("hold_ready_low", in_ready_s[0], 1'b0);
      chk("hold_yv_high", yv_s[0], 1'b1);
      cycles(1);
    end
    chk("after_hold_yv", yv_s[0], 1'b0);
    chk("after_hold_ready", in_ready_s[0], 1'b1);
    cycles(2);

    // in_valid held: code 7 then code 0, back to back with one idle cycle
    q[0].push_back('{y: 8'h80, len: 4, gap: 0});
    q[0].push_back('{y: 8'h01, len: 4, gap: 5});
    in_valid_s[0] = 1'b1;
    code_s[0]     = 3'd7;
`ifdef DECODER_PARITY_EN
    par_s[0]      = 1'b1;
`endif
    @(posedge clk); #1;
    code_s[0] = 3'd0;
`ifdef DECODER_PARITY_EN
    par_s[0]  = 1'b0;
`endif
    chk("held_ready_low", in_ready_s[0], 1'b0);
    wait_ready(0);
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    cycles(6);

    // abort with en during the second hold cycle of code 5
    q[0].push_back('{y: 8'h20, len: 2, gap: 0});
    send(0, 3'd5);
    cycles(1);
    en_s[0] = 1'b1;
    #1;
    chk("en_ready_low", in_ready_s[0], 1'b0);
    @(posedge clk); #1;
    chk("en_y_zero", y_s[0], 8'h00);
    chk("en_yv_zero", yv_s[0], 1'b0);
    chk("en_ready_idle_low", in_ready_s[0], 1'b0);
    in_valid_s[0] = 1'b1;
    code_s[0]     = 3'd2;
    @(posedge clk); #1;
    chk("en_blocks_accept", yv_s[0], 1'b0);
    in_valid_s[0] = 1'b0;
    en_s[0]       = 1'b0;
    #1;
    chk("en_release_ready", in_ready_s[0], 1'b1);
    cycles(2);

`ifdef DECODER_PARITY_EN
    // bad parity: consumed, err pulse, no decode
    in_valid_s[0] = 1'b1;
    code_s[0]     = 3'b011;
    par_s[0]      = 1'b1;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    chk("par_err_pulse", err_s[0], 1'b1);
    chk("par_y_zero", y_s[0], 8'h00);
    chk("par_ready", in_ready_s[0], 1'b1);
    cycles(1);
    chk("par_err_clear", err_s[0], 1'b0);
    q[0].push_back('{y: 8'h08, len: 4, gap: 0});
    send(0, 3'b011);
    chk("par_good_no_err", err_s[0], 1'b0);
    cycles(5);
`else
    chk("err_tied_dut4", err_s[0], 1'b0);
    chk("err_tied_dut1", err_s[1], 1'b0);
`endif

    // HOLD=1 sweep of all codes at a two-cycle period
    for (int c = 0; c < 8; c++) begin
      q[1].push_back('{y: 8'(1 << c), len: 1, gap: (c == 0) ? 0 : 2});
      chk("sweep_ready", in_ready_s[1], 1'b1);
      send(1, 3'(c));
      cycles(1);
    end
    cycles(2);

    // asynchronous reset in the middle of a hold
    q[0].push_back('{y: 8'h08, len: 2, gap: 0});
    send(0, 3'd3);
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_y", y_s[0], 8'h00);
    chk("async_rst_yv", yv_s[0], 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", in_ready_s[0], 1'b1);
    cycles(3);

    chk("dut4_queue_empty", q[0].size(), 0);
    chk("dut1_queue_empty", q[1].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
